// File: rtl/boot_stream_loader_if.sv
// boot_stream_loader_if: byte stream in (start, in_valid/in_ready/in_data), boot port out (boot_up/boot_addr/boot_datai), status (busy/done/err)
interface boot_stream_loader_if #(parameter int ADDR_WIDTH = 8);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic boot_up;
  logic [ADDR_WIDTH-1:0] boot_addr;
  logic [31:0] boot_datai;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, boot_up, boot_addr, boot_datai, busy, done, err
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, boot_up, boot_addr, boot_datai, busy, done, err
  );
endinterface

// File: rtl/boot_stream_loader.sv
// boot_stream_loader: framed byte stream to little-endian Icache words with checksum gate; ports clk, rst, bus (slave: start/in_* in, in_ready/boot_*/busy/done/err out)
module boot_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int ADDR_NUM   = 256
) (
  input logic clk,
  input logic rst,
  boot_stream_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CHECK, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [7:0] hdr_lo_q, hdr_lo_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH:0] word_idx_q, word_idx_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] csum_q, csum_d;
  logic [23:0] asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] datai_q, datai_d;
  logic [15:0] hdr;
  logic active;
  logic xfer;
  assign active = state_q inside {HDR_LO, HDR_HI, DATA, CHECK};
  assign xfer = bus.in_valid & active;
  assign hdr = {bus.in_data, hdr_lo_q};
  assign bus.in_ready = active;
  assign bus.busy = active;
  assign bus.boot_up = active | (state_q == ERR);
  assign bus.done = state_q == DONE;
  assign bus.err = state_q == ERR;
  assign bus.boot_addr = addr_q;
  assign bus.boot_datai = datai_q;
  always_comb begin
    state_d = state_q;
    hdr_lo_d = hdr_lo_q;
    last_d = last_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    csum_d = csum_q;
    asm_d = asm_q;
    addr_d = addr_q;
    datai_d = datai_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.start) begin
        state_d = HDR_LO;
        word_idx_d = '0;
        byte_idx_d = '0;
        csum_d = '0;
        addr_d = '0;
        datai_d = '0;
      end
      HDR_LO: if (xfer) begin
        hdr_lo_d = bus.in_data;
        state_d = HDR_HI;
      end
      HDR_HI: if (xfer) begin
        last_d = hdr[ADDR_WIDTH-1:0];
        state_d = ({1'b0, hdr} <= 17'(ADDR_NUM - 1)) ? DATA : ERR;
      end
      DATA: if (xfer) begin
        csum_d = csum_q ^ bus.in_data;
        byte_idx_d = byte_idx_q + 2'd1;
        asm_d = {bus.in_data, asm_q[23:8]};
        if (byte_idx_q == 2'd3) begin
          datai_d = {bus.in_data, asm_q};
          addr_d = word_idx_q[ADDR_WIDTH-1:0];
          word_idx_d = word_idx_q + (ADDR_WIDTH + 1)'(1);
          state_d = (word_idx_q == {1'b0, last_q}) ? CHECK : DATA;
        end
      end
      CHECK: if (xfer) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hdr_lo_q <= '0;
      last_q <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      csum_q <= '0;
      asm_q <= '0;
      addr_q <= '0;
      datai_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_lo_q <= hdr_lo_d;
      last_q <= last_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      csum_q <= csum_d;
      asm_q <= asm_d;
      addr_q <= addr_d;
      datai_q <= datai_d;
    end
  end
endmodule

// File: tb/tb_boot_stream_loader.sv
// tb_boot_stream_loader: randomized frames against an Icache-image scoreboard for boot_stream_loader
module tb_boot_stream_loader;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  boot_stream_loader_if #(.ADDR_WIDTH(8)) bif ();
  boot_stream_loader #(.ADDR_WIDTH(8), .ADDR_NUM(256)) dut (.clk(clk), .rst(rst), .bus(bif));
  typedef struct {
    bit ok;
    int n;
    logic [31:0] w[256];
  } exp_t;
  exp_t expq[$];
  exp_t me;
  logic [31:0] mem[256];
  int errors = 0;
  int checks = 0;
  logic busy_p = 0, done_p = 0, err_p = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.busy && !busy_p) for (int i = 0; i < 256; i++) mem[i] = '0;
      if (bif.boot_up) mem[bif.boot_addr] = bif.boot_datai;
      if ((bif.done && !done_p) || (bif.err && !err_p)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: done=%0b err=%0b with nothing expected", bif.done, bif.err);
        end else begin
          me = expq.pop_front();
          chk("status_done_err", {bif.done, bif.err}, me.ok ? 2'b10 : 2'b01);
          if (me.ok) begin
            for (int i = 0; i < me.n; i++) chk($sformatf("word[%0d]", i), mem[i], me.w[i]);
            chk("last_addr", bif.boot_addr, me.n - 1);
          end
        end
      end
    end
    busy_p = bif.busy;
    done_p = bif.done;
    err_p = bif.err;
  end
  task automatic pulse_start();
    bif.start = 1;
    @(negedge clk);
    bif.start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    bif.in_valid = 1;
    bif.in_data = b;
    while (!bif.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bif.in_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: in_ready=0 expected 1");
    end
    @(negedge clk);
    bif.in_valid = 0;
  endtask
  task automatic run_frame(input logic [31:0] w[$], input bit bad, input int gap, input int restart_at);
    logic [7:0] b[$];
    logic [7:0] cs = 0;
    logic [15:0] h = 16'(w.size() - 1);
    exp_t e;
    e.ok = !bad;
    e.n = w.size();
    b.push_back(h[7:0]);
    b.push_back(h[15:8]);
    foreach (w[i]) begin
      e.w[i] = w[i];
      for (int k = 0; k < 4; k++) begin
        b.push_back(w[i][8*k +: 8]);
        cs ^= w[i][8*k +: 8];
      end
    end
    b.push_back(bad ? ~cs : cs);
    expq.push_back(e);
    pulse_start();
    foreach (b[i]) begin
      if (i == restart_at) pulse_start();
      send_byte(b[i], gap ? int'($urandom_range(0, gap)) : 0);
    end
  endtask
  logic [31:0] w2[$], wr[$];
  exp_t eh;
  initial begin
    bif.start = 0;
    bif.in_valid = 0;
    bif.in_data = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_boot_up", bif.boot_up, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done_err", {bif.done, bif.err}, 0);
    chk("rst_in_ready", bif.in_ready, 0);
    chk("rst_addr_data", {bif.boot_addr, bif.boot_datai}, 0);
    bif.in_valid = 1;
    bif.in_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", bif.in_ready, 0);
    chk("idle_busy", bif.busy, 0);
    bif.in_valid = 0;
    w2 = '{32'h00000013, 32'h00100093};
    run_frame(w2, 0, 0, -1);
    chk("t2_done", bif.done, 1);
    chk("t2_boot_up", bif.boot_up, 0);
    chk("t2_busy", bif.busy, 0);
    chk("t2_last_pair", {bif.boot_addr, bif.boot_datai}, {8'd1, 32'h00100093});
    run_frame(w2, 1, 0, -1);
    chk("t3_err", bif.err, 1);
    chk("t3_done", bif.done, 0);
    chk("t3_boot_up", bif.boot_up, 1);
    chk("t3_in_ready", bif.in_ready, 0);
    run_frame(w2, 0, 0, -1);
    chk("t3_recover_done", bif.done, 1);
    eh.ok = 0;
    eh.n = 0;
    expq.push_back(eh);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    chk("t4_hdr_err", bif.err, 1);
    chk("t4_in_ready", bif.in_ready, 0);
    bif.in_valid = 1;
    repeat (3) @(negedge clk);
    chk("t4_no_consume", {bif.in_ready, bif.busy}, 0);
    bif.in_valid = 0;
    wr.delete();
    for (int i = 0; i < 256; i++) wr.push_back($urandom);
    run_frame(wr, 0, 0, -1);
    chk("t4_full_done", bif.done, 1);
    chk("t4_full_last_addr", bif.boot_addr, 8'd255);
    run_frame(w2, 0, 3, 4);
    chk("t5_gaps_done", bif.done, 1);
    for (int f = 0; f < 8; f++) begin
      wr.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) wr.push_back($urandom);
      run_frame(wr, $urandom_range(0, 3) == 0, 3, -1);
    end
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 0);
    rst = 1;
    @(negedge clk);
    chk("t6_boot_up", bif.boot_up, 0);
    chk("t6_idle", {bif.busy, bif.in_ready, bif.done, bif.err}, 0);
    chk("t6_addr", bif.boot_addr, 0);
    rst = 0;
    @(negedge clk);
    wr.delete();
    for (int i = 0; i < 3; i++) wr.push_back($urandom);
    pulse_start();
    chk("t6_reload_addr", {bif.boot_addr, bif.boot_datai}, 0);
    eh.ok = 1;
    eh.n = 3;
    for (int i = 0; i < 3; i++) eh.w[i] = wr[i];
    expq.push_back(eh);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    begin
      logic [7:0] cs = 0;
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 4; k++) begin
          send_byte(wr[i][8*k +: 8], 0);
          cs ^= wr[i][8*k +: 8];
        end
      send_byte(cs, 0);
    end
    chk("t6_reload_done", bif.done, 1);
    for (int t = 0; t < 100 && expq.size() != 0; t++) @(negedge clk);
    chk("pending_expected", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
